simd_run_ctrl: RTL
==================

Name: simd_run_ctrl

Overview:
- Synthesizable run sequencer for the SIMD core (top), replacing the hand-timed reset/valid stimulus.
- Holds the core in reset for a programmable time, then pulses the core's valid, counts cycles until the core's stop, and repeats for N back-to-back runs.
- Has a watchdog timeout, plus per-run and accumulated cycle counts for performance measurement. Sits between the bench/host and the core's rstn/valid/stop pins.

Parameters:
- CNT_WIDTH, 16, width of per-run cycle counter and watchdog limit.
- TOT_WIDTH, 32, width of accumulated cycle counter.
- RUN_WIDTH, 8, width of run-count and run-index fields.
- HOLD_CYCLES, 12, cycles core_rstn is held low before each run (must be ≥1).
- VALID_CYCLES, 1, cycles core_valid is held high per launch (must be ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- num_runs  in  RUN_WIDTH  runs per batch, latched on accepted start; 0 is treated as 1
- timeout_lim  in  CNT_WIDTH  watchdog limit in cycles, latched on accepted start
- core_rstn  out  1  active-low reset to core
- core_valid  out  1  launch strobe to core
- core_stop  in  1  core completion, level or pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- timeout_err  out  1  sticky; set on watchdog expiry, cleared on next accepted start
- run_idx  out  RUN_WIDTH  index of current/last run, 0-based
- last_cycles  out  CNT_WIDTH  cycle count of most recently completed run
- total_cycles  out  TOT_WIDTH  sum of last_cycles over the batch, saturating

Behaviour:
- Reset values:
  - core_rstn=0, core_valid=0, busy=0, done=0, timeout_err=0.
  - run_idx=0, last_cycles=0, total_cycles=0.
  - State is IDLE.
- FSM states: IDLE, HOLD, LAUNCH, RUN, RECORD, FINISH.
- IDLE:
  - core_rstn=0.
  - When start=1: latch num_runs and timeout_lim, clear timeout_err, run_idx, total_cycles; go to HOLD next cycle.
- HOLD:
  - core_rstn=0 for exactly HOLD_CYCLES cycles, then go to LAUNCH.
  - core_rstn rises on the first LAUNCH cycle.
- LAUNCH:
  - core_rstn=1, core_valid=1 for exactly VALID_CYCLES cycles.
  - Per-run counter cleared to 0 on entry.
  - core_stop is ignored here.
  - Then go to RUN.
- RUN:
  - core_rstn=1, core_valid=0.
  - Counter increments each cycle; first RUN cycle counts 1, saturating at all-ones.
  - core_stop=1 in a RUN cycle: that cycle is counted; go to RECORD.
  - Watchdog: if the counter equals timeout_lim and core_stop=0, set timeout_err and go to FINISH without updating last_cycles.
  - timeout_lim=0 disables the watchdog.
  - If core_stop=1 and the counter reaches the limit in the same cycle, stop wins: no error.
- RECORD (1 cycle):
  - last_cycles←counter.
  - total_cycles←total_cycles+counter, saturating at all-ones.
  - If run_idx==latched_runs−1, go to FINISH. Otherwise run_idx increments and go to HOLD; the core is re-reset before every run.
- FINISH (1 cycle):
  - done=1, core_rstn=0; go to IDLE.
  - run_idx keeps the final or failing index.
- start while busy: ignored, no queuing.
- Mid-operation rst: everything returns to reset values asynchronously, including core_rstn=0. No done pulse.
- All outputs are registered; no combinational path from start/core_stop to outputs.

Optional Feature:
- Macro: SIMD_RUN_MINMAX_EN.
- Defined:
  - Adds outputs min_cycles and max_cycles (CNT_WIDTH each).
  - On accepted start: min_cycles←all-ones, max_cycles←0.
  - Each RECORD updates min/max with the counter.
  - Reset values: min_cycles all-ones, max_cycles 0.
  - Timed-out runs do not update min/max.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst held, then released; start with num_runs=1, timeout_lim=100; core_stop pulses 20 cycles after the core_valid falling edge.
  - core_rstn low 12 cycles, core_valid high 1 cycle.
  - last_cycles=21, total_cycles=21, done 1 cycle, timeout_err=0.
- num_runs=3, core stops after 5, 7 and 9 RUN cycles.
  - Three HOLD/LAUNCH sequences; run_idx reaches 2.
  - last_cycles=9, total_cycles=21, a single done.
  - With SIMD_RUN_MINMAX_EN: min=5, max=9.
- timeout_lim=50, core_stop never asserted.
  - After 50 RUN cycles: timeout_err=1, done pulses, run_idx=0, last_cycles unchanged.
  - Next start clears timeout_err.
- core_stop asserted on exactly the 50th RUN cycle with timeout_lim=50.
  - Run completes normally: last_cycles=50, timeout_err=0.
- start pulsed during RUN; rst asserted mid-HOLD of run 2 of 3.
  - The extra start has no effect.
  - On rst: all outputs return to reset values immediately; no done.
- num_runs=0, timeout_lim=0; core stops after 3000 cycles with CNT_WIDTH=16.
  - Exactly one run, no timeout, last_cycles=3000.

Source files
------------

// File: rtl/simd_run_ctrl.sv
// simd_run_ctrl: run sequencer for the SIMD core.
// Holds the core in reset, strobes valid, times each run until core_stop,
// repeats for a batch of runs and guards every run with a watchdog.
// Optional build macro: SIMD_RUN_MINMAX_EN adds min_cycles/max_cycles outputs.
module simd_run_ctrl #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned TOT_WIDTH    = 32,
  parameter int unsigned RUN_WIDTH    = 8,
  parameter int unsigned HOLD_CYCLES  = 12,
  parameter int unsigned VALID_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RUN_WIDTH-1:0] num_runs,
  input  logic [CNT_WIDTH-1:0] timeout_lim,
  output logic                 core_rstn,
  output logic                 core_valid,
  input  logic                 core_stop,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [RUN_WIDTH-1:0] run_idx,
  output logic [CNT_WIDTH-1:0] last_cycles,
  output logic [TOT_WIDTH-1:0] total_cycles
`ifdef SIMD_RUN_MINMAX_EN
  ,
  output logic [CNT_WIDTH-1:0] min_cycles,
  output logic [CNT_WIDTH-1:0] max_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_LAUNCH, S_RUN, S_RECORD, S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lim_q, lim_d;
  logic [RUN_WIDTH-1:0] runs_q, runs_d;
  logic [RUN_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [TOT_WIDTH-1:0] total_q, total_d;
  logic                 terr_q, terr_d;
  logic                 rstn_q, rstn_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [TOT_WIDTH:0]   sum_w;
`ifdef SIMD_RUN_MINMAX_EN
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
`endif

  // State and registered outputs; async reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      runs_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      total_q <= '0;
      terr_q  <= 1'b0;
      rstn_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIMD_RUN_MINMAX_EN
      min_q   <= '1;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      runs_q  <= runs_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      total_q <= total_d;
      terr_q  <= terr_d;
      rstn_q  <= rstn_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIMD_RUN_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so that they
  // come straight out of flops and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    runs_d  = runs_q;
    idx_d   = idx_q;
    last_d  = last_q;
    total_d = total_q;
    terr_d  = terr_q;
`ifdef SIMD_RUN_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    sum_w   = {1'b0, total_q} + (TOT_WIDTH+1)'(cnt_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          runs_d  = (num_runs == '0) ? RUN_WIDTH'(1) : num_runs;
          lim_d   = timeout_lim;
          terr_d  = 1'b0;
          idx_d   = '0;
          total_d = '0;
          phase_d = '0;
`ifdef SIMD_RUN_MINMAX_EN
          min_d   = '1;
          max_d   = '0;
`endif
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (phase_q == HOLD_CYCLES - 1) begin
          phase_d = '0;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_LAUNCH: begin
        if (phase_q == VALID_CYCLES - 1) begin
          phase_d = '0;
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (core_stop) begin
          state_d = S_RECORD;
        end else if ((lim_q != '0) && (cnt_inc == lim_q)) begin
          terr_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_RECORD: begin
        last_d  = cnt_q;
        total_d = sum_w[TOT_WIDTH] ? '1 : sum_w[TOT_WIDTH-1:0];
`ifdef SIMD_RUN_MINMAX_EN
        if (cnt_q < min_q) min_d = cnt_q;
        if (cnt_q > max_q) max_d = cnt_q;
`endif
        if (idx_q == runs_q - RUN_WIDTH'(1)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + RUN_WIDTH'(1);
          phase_d = '0;
          state_d = S_HOLD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    rstn_d  = (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_RECORD);
    valid_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
  end

  assign core_rstn    = rstn_q;
  assign core_valid   = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = terr_q;
  assign run_idx      = idx_q;
  assign last_cycles  = last_q;
  assign total_cycles = total_q;
`ifdef SIMD_RUN_MINMAX_EN
  assign min_cycles   = min_q;
  assign max_cycles   = max_q;
`endif

endmodule
